if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter WORD_LEN, default `WORD_LEN (32), width of PC, offset and instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 freeze  input  1  hazard stall from the decode stage; holds PC and IF/ID outputs.
REQ-006 br_taken  input  1  decode stage resolved a taken branch for the instruction currently in IF/ID.
REQ-007 br_offset  input  WORD_LEN  sign-extended branch immediate, in words, from the decode stage.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  WORD_LEN  byte address of fetch, equals PC.
REQ-010 imem_ready  input  1  memory data valid this cycle for the current imem_addr.
REQ-011 imem_rdata  input  WORD_LEN  fetched instruction word.
REQ-012 pc_out  output  WORD_LEN  IF/ID register: fetch PC + 4.
REQ-013 instruction  output  WORD_LEN  IF/ID register: fetched instruction, feeds the decode stage.
REQ-014 if_valid  output  1  IF/ID register holds a real instruction (0 = bubble).

Function
REQ-015 States: FETCH (imem_req=1, imem_addr=PC) and BUF (valid word held in skid buffer, imem_req=0; exists only with IF_SKID_BUF_EN).
REQ-016 Memory samples imem_addr every cycle imem_req=1; changing imem_addr mid-request is legal and cancels the previous fetch.
REQ-017 Accept condition: state FETCH, imem_ready=1, freeze=0, br_taken=0; on that edge IF/ID <= {PC+4, imem_rdata}, if_valid <= 1, PC <= PC+4.
REQ-018 FETCH with imem_ready=0, freeze=0, br_taken=0: PC holds, if_valid <= 0, pc_out/instruction hold; bubble inserted.
REQ-019 freeze=1, br_taken=0: PC, pc_out, instruction, if_valid all hold their values.
REQ-020 br_taken=1: PC <= pc_out + (br_offset << 2), mod 2^32; if_valid <= 0; instruction <= 0; pc_out holds; state <= FETCH; any ready or buffered word discarded.
REQ-021 br_taken has priority over freeze and imem_ready when asserted in the same cycle.
REQ-022 PC+4 and branch-target arithmetic wraps at 2^32 with no flag.
REQ-023 Latency: instruction returned with imem_ready in cycle N is visible on instruction/if_valid in cycle N+1.
REQ-024 Throughput: one instruction per cycle when imem_ready=1 continuously and freeze=0.

Reset
REQ-025 rst=0 asynchronously sets PC=RESET_PC, pc_out=0, instruction=0, if_valid=0, state=FETCH, skid buffer empty.
REQ-026 imem_req=0 while rst=0; imem_req=1 from the first cycle after rst deasserts.
REQ-027 Reset asserted mid-fetch or mid-freeze abandons the transaction; no partial IF/ID update.

Configuration
REQ-028 Macro IF_SKID_BUF_EN compiles in a single-entry skid buffer.
REQ-029 Without IF_SKID_BUF_EN: imem_req=0 while freeze=1; fetch at the same PC resumes the cycle freeze drops; BUF state absent.
REQ-030 With IF_SKID_BUF_EN: imem_req stays 1 in FETCH during freeze; imem_ready=1 under freeze captures imem_rdata into the buffer, PC <= PC+4, state <= BUF.
REQ-031 With IF_SKID_BUF_EN, in BUF with freeze=0 and br_taken=0: IF/ID <= {buffered PC+4, buffered word}, if_valid <= 1, state <= FETCH; no memory access that cycle.
REQ-032 With IF_SKID_BUF_EN, br_taken in BUF empties the buffer per REQ-020.

Verification
REQ-033 Reset release, RESET_PC=0, imem_ready=1 always, rdata=addr -> imem_addr 0,4,8,12 on consecutive cycles; instruction 0,4,8 one cycle later; pc_out 4,8,12.
REQ-034 imem_ready=0 for 3 cycles at PC=8 -> imem_addr stays 8, if_valid=0 for 3 cycles, then instruction=8, pc_out=12.
REQ-035 freeze=1 for 2 cycles with IF/ID={8,4} -> pc_out=8, instruction=4 held, PC unchanged (no buffer) or PC+4 with buffer filled (IF_SKID_BUF_EN), then next word delivered after freeze drops.
REQ-036 pc_out=16, br_offset=-2, br_taken=1 together with freeze=1 -> next PC=8, if_valid=0, instruction=0; fetch resumes at 8.
REQ-037 pc_out=32'hFFFF_FFF8, br_offset=3 -> PC wraps to 32'h0000_0004.
REQ-038 rst pulsed low mid-stall with IF_SKID_BUF_EN and buffer full -> outputs 0, PC=RESET_PC, buffer empty, no stale word delivered.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// Ports: imem_req/imem_addr from the fetch stage, imem_ready/imem_rdata from memory.
// Memory samples imem_addr on every cycle imem_req is high; a new address cancels the old one.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface if_stage_if #(
  parameter int WORD_LEN = `WORD_LEN
) ();

  logic                imem_req;    // fetch request
  logic [WORD_LEN-1:0] imem_addr;   // byte address of the fetch
  logic                imem_ready;  // rdata valid for the current imem_addr
  logic [WORD_LEN-1:0] imem_rdata;  // fetched instruction word

  // Fetch-stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Instruction-memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage.sv
// Purpose : instruction fetch stage; owns the PC, drives instruction memory, fills IF/ID.
// Latency : word returned with imem_ready in cycle N appears on instruction/if_valid in N+1.
// Backpr. : freeze holds PC and IF/ID; imem_ready=0 inserts a bubble; br_taken overrides both.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   freeze                decode-stage hazard stall
//   br_taken, br_offset   taken branch for the instruction in IF/ID, word offset
//   imem (master)         instruction-memory fetch bus (req/addr out, ready/rdata in)
//   pc_out, instruction   IF/ID register: fetch PC + 4 and fetched word
//   if_valid              IF/ID holds a real instruction (0 = bubble)
//
// Build option: define IF_SKID_BUF_EN to add a single-entry skid buffer that keeps
// fetching during a freeze and parks the returned word until the stall clears.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module if_stage #(
  parameter int                  WORD_LEN = `WORD_LEN,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_offset,
  if_stage_if.master          imem,
  output logic [WORD_LEN-1:0] pc_out,
  output logic [WORD_LEN-1:0] instruction,
  output logic                if_valid
);

  // Architectural state
  logic [WORD_LEN-1:0] pc_q,     pc_d;
  logic [WORD_LEN-1:0] pc_out_q, pc_out_d;
  logic [WORD_LEN-1:0] instr_q,  instr_d;
  logic                valid_q,  valid_d;

  // Sequential PC and branch target; both wrap silently at 2^WORD_LEN.
  logic [WORD_LEN-1:0] pc_inc;
  logic [WORD_LEN-1:0] br_target;

  assign pc_inc    = pc_q + WORD_LEN'(4);
  assign br_target = pc_out_q + (br_offset << 2);

`ifdef IF_SKID_BUF_EN
  // FETCH: request outstanding at pc_q. BUF: a word fetched under freeze is parked
  // in buf_dat_q and memory is idle until it is handed to decode.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_BUF   = 1'b1
  } state_e;

  state_e              state_q,   state_d;
  logic [WORD_LEN-1:0] buf_dat_q, buf_dat_d;
`endif

  // ---------------------------------------------------------------------------
  // Fetch request
  // ---------------------------------------------------------------------------
  always_comb begin
    imem.imem_addr = pc_q;
`ifdef IF_SKID_BUF_EN
    // Keep fetching through a freeze; the buffer absorbs one returned word.
    imem.imem_req  = rst && (state_q == S_FETCH);
`else
    // Without a buffer there is nowhere to put a word returned under freeze.
    imem.imem_req  = rst && !freeze;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
`ifdef IF_SKID_BUF_EN
    state_d   = state_q;
    buf_dat_d = buf_dat_q;
`endif

    if (br_taken) begin
      // Redirect wins over freeze and ready: any in-flight or parked word is
      // on the wrong path, so drop it and squash IF/ID. pc_out is kept.
      pc_d    = br_target;
      instr_d = '0;
      valid_d = 1'b0;
`ifdef IF_SKID_BUF_EN
      state_d   = S_FETCH;
      buf_dat_d = '0;
`endif
    end else begin
`ifdef IF_SKID_BUF_EN
      case (state_q)
        S_FETCH: begin
          if (!freeze) begin
            if (imem.imem_ready) begin
              pc_out_d = pc_inc;
              instr_d  = imem.imem_rdata;
              valid_d  = 1'b1;
              pc_d     = pc_inc;
            end else begin
              valid_d = 1'b0;
            end
          end else if (imem.imem_ready) begin
            // Park the word; PC moves on so pc_q already equals its PC + 4.
            buf_dat_d = imem.imem_rdata;
            pc_d      = pc_inc;
            state_d   = S_BUF;
          end
        end
        S_BUF: begin
          if (!freeze) begin
            // pc_q was advanced when the word was parked, so it is the word's PC + 4.
            pc_out_d = pc_q;
            instr_d  = buf_dat_q;
            valid_d  = 1'b1;
            state_d  = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
`else
      if (!freeze) begin
        if (imem.imem_ready) begin
          pc_out_d = pc_inc;
          instr_d  = imem.imem_rdata;
          valid_d  = 1'b1;
          pc_d     = pc_inc;
        end else begin
          valid_d = 1'b0;
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
`ifdef IF_SKID_BUF_EN
      state_q   <= S_FETCH;
      buf_dat_q <= '0;
`endif
    end else begin
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
`ifdef IF_SKID_BUF_EN
      state_q   <= state_d;
      buf_dat_q <= buf_dat_d;
`endif
    end
  end

  assign pc_out      = pc_out_q;
  assign instruction = instr_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stimulus against a behavioural model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        rdy;
  logic [31:0] salt;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        if_valid;

  int total;
  int bad;

  if_stage_if #(.WORD_LEN(32)) mem_if ();

  // Memory: always has data when the bench says so; word content is addr ^ salt.
  assign mem_if.imem_ready = rdy;
  assign mem_if.imem_rdata = mem_if.imem_addr ^ salt;

  if_stage #(
    .WORD_LEN (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .imem        (mem_if.master),
    .pc_out      (pc_out),
    .instruction (instruction),
    .if_valid    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: next fetch address, the IF/ID contents, and a list of
  // words waiting to be handed to decode (at most one, only with the buffer).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] next_pc;
    logic [31:0] word;
  } parked_t;

  logic [31:0] m_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_instr;
  logic        m_valid;
  parked_t     parked[$];

  task automatic model_reset();
    m_pc     = 32'h0;
    m_pc_out = 32'h0;
    m_instr  = 32'h0;
    m_valid  = 1'b0;
    parked.delete();
  endtask

  task automatic model_step(input logic fr, input logic bt, input logic [31:0] off, input logic r);
    logic [31:0] word;
    parked_t     p;
    word = m_pc ^ salt;
    if (bt) begin
      m_pc    = m_pc_out + off * 4;
      m_valid = 1'b0;
      m_instr = 32'h0;
      parked.delete();
    end else if (parked.size() != 0) begin
      if (!fr) begin
        p        = parked.pop_front();
        m_pc_out = p.next_pc;
        m_instr  = p.word;
        m_valid  = 1'b1;
      end
    end else if (!fr) begin
      if (r) begin
        m_instr  = word;
        m_pc_out = m_pc + 4;
        m_pc     = m_pc + 4;
        m_valid  = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
`ifdef IF_SKID_BUF_EN
      if (r) begin
        p.next_pc = m_pc + 4;
        p.word    = word;
        parked.push_back(p);
        m_pc = m_pc + 4;
      end
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc_out"}, pc_out, m_pc_out);
    chk({tag, ".instruction"}, instruction, m_instr);
    chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, m_valid});
  endtask

  task automatic check_fetch(input string tag);
    logic exp_req;
`ifdef IF_SKID_BUF_EN
    exp_req = rst && (parked.size() == 0);
`else
    exp_req = rst && !freeze;
`endif
    chk({tag, ".imem_req"}, {31'b0, mem_if.imem_req}, {31'b0, exp_req});
    if (exp_req) chk({tag, ".imem_addr"}, mem_if.imem_addr, m_pc);
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic cyc(input logic fr, input logic bt, input logic [31:0] off, input logic r);
    check_regs("regs");
    freeze    = fr;
    br_taken  = bt;
    br_offset = off;
    rdy       = r;
    #1;
    check_fetch("fetch");
    @(posedge clk);
    model_step(fr, bt, off, r);
    @(negedge clk);
  endtask

  task automatic accept(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Reset is applied asynchronously at a falling edge and must act at once.
  task automatic do_reset();
    rst       = 1'b0;
    freeze    = 1'b0;
    br_taken  = 1'b0;
    br_offset = 32'h0;
    rdy       = 1'b0;
    #1;
    model_reset();
    chk("rst.imem_req", {31'b0, mem_if.imem_req}, 32'h0);
    check_regs("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_regs("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    salt      = 32'h0;
    rst       = 1'b0;
    freeze    = 1'b0;
    br_taken  = 1'b0;
    br_offset = 32'h0;
    rdy       = 1'b0;
    model_reset();
    @(negedge clk);

    // Streaming fetch from reset: addr 0,4,8,12; data one cycle later.
    do_reset();
    accept(1);
    chk("s33.instr0", instruction, 32'h0);
    chk("s33.pc4", pc_out, 32'h4);
    accept(2);
    chk("s33.instr8", instruction, 32'h8);
    chk("s33.pc12", pc_out, 32'hC);
    chk("s33.addr12", mem_if.imem_addr, 32'hC);
    accept(1);
    chk("s33.pc16", pc_out, 32'h10);

    // Memory not ready for three cycles at PC 8.
    do_reset();
    accept(2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("s34.bubble", {31'b0, if_valid}, 32'h0);
      chk("s34.addr8", mem_if.imem_addr, 32'h8);
    end
    accept(1);
    chk("s34.instr8", instruction, 32'h8);
    chk("s34.pc12", pc_out, 32'hC);

    // Freeze for two cycles with IF/ID = {8, 4}.
    do_reset();
    accept(2);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("s35.pc_hold", pc_out, 32'h8);
    chk("s35.instr_hold", instruction, 32'h4);
    chk("s35.req_off", {31'b0, mem_if.imem_req}, 32'h0);
    accept(1);
    chk("s35.instr8", instruction, 32'h8);
    chk("s35.pc12", pc_out, 32'hC);
    accept(1);
    chk("s35.instr12", instruction, 32'hC);

    // Branch with freeze in the same cycle: pc_out 16, offset -2 -> PC 8.
    do_reset();
    accept(4);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk("s36.squash_v", {31'b0, if_valid}, 32'h0);
    chk("s36.squash_i", instruction, 32'h0);
    chk("s36.pc_keep", pc_out, 32'h10);
    accept(1);
    chk("s36.instr8", instruction, 32'h8);
    chk("s36.pc12", pc_out, 32'hC);

    // Branch target wrap: pc_out FFFF_FFF8 + 3 words -> 4.
    do_reset();
    accept(1);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    accept(1);
    chk("s37.pc_hi", pc_out, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 32'h0000_0003, 1'b1);
    accept(1);
    chk("s37.wrap_i", instruction, 32'h4);
    chk("s37.wrap_pc", pc_out, 32'h8);

    // PC + 4 wrap at the top of the address space.
    do_reset();
    accept(1);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
    accept(2);
    chk("inc_wrap.instr", instruction, 32'hFFFF_FFFC);
    chk("inc_wrap.pc", pc_out, 32'h0);
    accept(1);
    chk("inc_wrap.next", instruction, 32'h0);

    // Reset in the middle of a stall (buffer full when compiled in).
    do_reset();
    accept(1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("s38.no_stale_v", {31'b0, if_valid}, 32'h0);
    chk("s38.no_stale_i", instruction, 32'h0);
    accept(1);
    chk("s38.first_i", instruction, 32'h0);
    chk("s38.first_pc", pc_out, 32'h4);

    // Random traffic against the model.
    salt = $urandom;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic        fr;
      logic        bt;
      logic        r;
      logic [31:0] off;
      fr  = ($urandom_range(0, 3) == 0);
      bt  = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 3) != 0);
      off = 32'($urandom_range(0, 15)) - 32'd8;
      cyc(fr, bt, off, r);
    end
    check_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
